p4_parte1_mem_pattern_engine: RTL and testbench

- Avalon-MM master placed directly upstream of the 512x16 single-port on-chip memory; it drives that memory's s1 port.
- On start, it writes a selectable test pattern to every word, then reads each word back and compares it against the regenerated pattern.
- It reports pass/fail, an error count and the first failing address.
- It serves as the bring-up / self-test engine for the on-chip RAM.

---
 rtl/p4_parte1_memtest_pkg.sv | 21 ++
 rtl/p4_parte1_pattern_gen.sv | 44 ++++
 rtl/p4_parte1_mem_pattern_engine.sv | 152 +++++++++++++++
 tb/tb_p4_parte1_mem_pattern_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/p4_parte1_memtest_pkg.sv
// Shared encodings for the on-chip RAM pattern self-test engine.
// State and pattern encodings are plain logic constants so legacy code can compare them directly.
package p4_parte1_memtest_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef logic [1:0] pat_sel_t;
  localparam pat_sel_t PAT_INC     = 2'd0;
  localparam pat_sel_t PAT_CHECKER = 2'd1;
  localparam pat_sel_t PAT_LFSR    = 2'd2;
  localparam pat_sel_t PAT_CONST   = 2'd3;

  localparam logic [15:0] LFSR_TAPS_DEF      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/p4_parte1_pattern_gen.sv
// Test-pattern generator. Reloading it from the same seed replays the identical word sequence,
// which is how the read phase regenerates what the write phase stored.
module p4_parte1_pattern_gen
  import p4_parte1_memtest_pkg::*;
#(
  parameter int                 ADDR_W         = 9,
  parameter int                 DATA_W         = 16,
  parameter logic [DATA_W-1:0]  LFSR_TAPS      = DATA_W'(LFSR_TAPS_DEF),
  parameter logic [DATA_W-1:0]  LFSR_ZERO_SEED = DATA_W'(LFSR_ZERO_SEED_DEF)
) (
  input  logic              clk,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] seed,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pat
);

  logic [DATA_W-1:0] lfsr_q;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  always_ff @(posedge clk) begin
    if (load)
      lfsr_q <= (seed == '0) ? LFSR_ZERO_SEED : seed;
    else if (step)
      lfsr_q <= lfsr_next(lfsr_q);
  end

  always_comb begin
    pat = seed;
    case (sel)
      PAT_INC:     pat = seed + DATA_W'(addr);
      PAT_CHECKER: pat = addr[0] ? ~seed : seed;
      PAT_LFSR:    pat = lfsr_q;
      default:     pat = seed;
    endcase
  end

endmodule

// File: rtl/p4_parte1_mem_pattern_engine.sv
// Avalon-MM master that fills the on-chip RAM with a pattern, reads it back and reports
// pass/fail, the mismatch count and the first failing address.
module p4_parte1_mem_pattern_engine
  import p4_parte1_memtest_pkg::*;
#(
  parameter int                ADDR_W         = 9,
  parameter int                DATA_W         = 16,
  parameter int                DEPTH          = 512,
  parameter logic [DATA_W-1:0] LFSR_TAPS      = DATA_W'(LFSR_TAPS_DEF),
  parameter logic [DATA_W-1:0] LFSR_ZERO_SEED = DATA_W'(LFSR_ZERO_SEED_DEF)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          pattern_sel,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] exp_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        sel_q;
  logic [ADDR_W:0]   err_count_q;
  logic [ADDR_W-1:0] first_err_q;

  logic              start_acc;
  logic              at_last;
  logic              gen_load;
  logic              gen_step;
  logic [DATA_W-1:0] gen_seed;
  logic [1:0]        gen_sel;
  logic [DATA_W-1:0] gen_pat;
  logic              mismatch;

  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign start_acc = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign at_last   = (addr_p0 == LAST_ADDR);

  // The generator sees the live seed/select on the accepting edge, the captured copy afterwards.
  assign gen_seed = start_acc ? seed : seed_q;
  assign gen_sel  = start_acc ? pattern_sel : sel_q;
  assign gen_load = start_acc || ((state_q == ST_WRITE) && at_last);
  assign gen_step = ((state_q == ST_WRITE) || (state_q == ST_READ)) && !at_last;

  p4_parte1_pattern_gen #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .LFSR_TAPS      (LFSR_TAPS),
    .LFSR_ZERO_SEED (LFSR_ZERO_SEED)
  ) u_pattern_gen (
    .clk  (clk),
    .sel  (gen_sel),
    .seed (gen_seed),
    .load (gen_load),
    .step (gen_step),
    .addr (addr_p0),
    .pat  (gen_pat)
  );

  assign mismatch = vld_p1 && (readdata != exp_p1) && !(abort && busy);

  // Stage p0 -> p1: control path (state, address counter, compare-valid, error capture)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_p0     <= '0;
      vld_p1      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      vld_p1 <= (state_q == ST_READ) && !abort;
      if (mismatch) begin
        err_count_q <= err_count_q + (ADDR_W+1)'(1);
        if (err_count_q == '0)
          first_err_q <= addr_p1;
      end
      if (abort) begin
        state_q <= ST_IDLE;
        addr_p0 <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q     <= ST_WRITE;
              addr_p0     <= '0;
              err_count_q <= '0;
              first_err_q <= '0;
            end
          end
          ST_WRITE: begin
            if (at_last) begin
              state_q <= ST_READ;
              addr_p0 <= '0;
            end else begin
              addr_p0 <= addr_p0 + ADDR_W'(1);
            end
          end
          ST_READ: begin
            if (at_last) begin
              state_q <= ST_DRAIN;
              addr_p0 <= '0;
            end else begin
              addr_p0 <= addr_p0 + ADDR_W'(1);
            end
          end
          ST_DRAIN: state_q <= ST_DONE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage p0 -> p1: data path (expected word, its address, captured test setup)
  always_ff @(posedge clk) begin
    exp_p1  <= gen_pat;
    addr_p1 <= addr_p0;
    if (start_acc) begin
      seed_q <= seed;
      sel_q  <= pattern_sel;
    end
  end

  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_count_q == '0);
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign address        = addr_p0;
  assign chipselect     = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign write          = (state_q == ST_WRITE);
  assign writedata      = write ? gen_pat : '0;
  assign byteenable     = '1;
  assign clken          = 1'b1;

endmodule

// File: tb/tb_p4_parte1_mem_pattern_engine.sv
// Directed bench for the RAM pattern engine with a 1-cycle-latency RAM model that can corrupt reads.
module tb_p4_parte1_mem_pattern_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [1:0]  pattern_sel;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic        pass;
  logic [9:0]  err_count;
  logic [8:0]  first_err_addr;
  logic [8:0]  address;
  logic [1:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [15:0] writedata;
  logic        clken;
  logic [15:0] readdata;

  logic [15:0] mem [0:511];
  logic        corrupt = 1'b0;
  int          cs_count = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  p4_parte1_mem_pattern_engine dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .pattern_sel    (pattern_sel),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .address        (address),
    .byteenable     (byteenable),
    .chipselect     (chipselect),
    .write          (write),
    .writedata      (writedata),
    .clken          (clken),
    .readdata       (readdata)
  );

  // Single-port RAM: write on the edge, read data one cycle after the address.
  always @(posedge clk) begin
    if (chipselect && write)
      mem[address] <= writedata;
    readdata <= mem[address] ^
                ((corrupt && (address == 9'h005 || address == 9'h1F0)) ? 16'h0100 : 16'h0000);
  end

  always @(negedge clk)
    if (chipselect) cs_count++;

  task automatic run_test(input logic [1:0] sel, input logic [15:0] sd, input int inject_at,
                          output int cycles, output logic [10:0] first_bus);
    pattern_sel = sel;
    seed = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    first_bus = {chipselect, write, address};
    while (!done && cycles < 3000) begin
      if (cycles == inject_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, pass}); end
    checks++; if ({err_count, first_err_addr} !== 19'h0) begin errors++; $display("FAIL reset_err got %h exp 0", {err_count, first_err_addr}); end
    checks++; if ({address, chipselect, write, writedata} !== 27'h0) begin errors++; $display("FAIL reset_bus got %h exp 0", {address, chipselect, write, writedata}); end
    checks++; if ({byteenable, clken} !== 3'b111) begin errors++; $display("FAIL reset_const got %b exp 111", {byteenable, clken}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, chipselect} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b exp 000", {busy, done, chipselect}); end
  endtask

  task automatic test_increment;
    int cycles;
    logic [10:0] fb;
    run_test(2'd0, 16'h0000, -1, cycles, fb);
    checks++; if (fb !== {2'b11, 9'h000}) begin errors++; $display("FAIL inc_first_write got %h exp %h", fb, {2'b11, 9'h000}); end
    checks++; if (cycles != 1026) begin errors++; $display("FAIL inc_done_cycle got %0d exp 1026", cycles); end
    checks++; if (mem[9'h1FF] !== 16'h01FF) begin errors++; $display("FAIL inc_word_1ff got %h exp 01ff", mem[9'h1FF]); end
    checks++; if ({done, pass, busy} !== 3'b110) begin errors++; $display("FAIL inc_status got %b exp 110", {done, pass, busy}); end
    checks++; if ({err_count, first_err_addr} !== 19'h0) begin errors++; $display("FAIL inc_err got %h exp 0", {err_count, first_err_addr}); end
    @(posedge clk); #1;
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL done_held got %b exp 11", {done, pass}); end
  endtask

  task automatic test_checkerboard;
    int cycles;
    logic [10:0] fb;
    run_test(2'd1, 16'h5555, -1, cycles, fb);
    checks++; if (mem[0] !== 16'h5555) begin errors++; $display("FAIL chk_addr0 got %h exp 5555", mem[0]); end
    checks++; if (mem[1] !== 16'hAAAA) begin errors++; $display("FAIL chk_addr1 got %h exp aaaa", mem[1]); end
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL chk_pass got %b exp 11", {done, pass}); end
  endtask

  task automatic test_lfsr;
    int cycles;
    logic [10:0] fb;
    run_test(2'd2, 16'h0000, -1, cycles, fb);
    checks++; if (mem[0] !== 16'hACE1) begin errors++; $display("FAIL lfsr_word0 got %h exp ace1", mem[0]); end
    checks++; if (mem[1] !== 16'hE270) begin errors++; $display("FAIL lfsr_word1 got %h exp e270", mem[1]); end
    checks++; if ({done, pass, err_count} !== {2'b11, 10'd0}) begin errors++; $display("FAIL lfsr_pass got %h exp %h", {done, pass, err_count}, {2'b11, 10'd0}); end
  endtask

  task automatic test_errors;
    int cycles;
    logic [10:0] fb;
    corrupt = 1'b1;
    run_test(2'd3, 16'h1234, -1, cycles, fb);
    corrupt = 1'b0;
    checks++; if (err_count !== 10'd2) begin errors++; $display("FAIL err_count got %0d exp 2", err_count); end
    checks++; if (first_err_addr !== 9'h005) begin errors++; $display("FAIL first_err_addr got %h exp 005", first_err_addr); end
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL err_pass got %b exp 10", {done, pass}); end
    checks++; if (cycles != 1026) begin errors++; $display("FAIL err_done_cycle got %0d exp 1026", cycles); end
  endtask

  task automatic test_abort;
    int cycles;
    logic [10:0] fb;
    pattern_sel = 2'd0;
    seed = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++; if ({write, address} !== {1'b1, 9'd100}) begin errors++; $display("FAIL abort_setup got %h exp %h", {write, address}, {1'b1, 9'd100}); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({busy, chipselect, write, done} !== 4'b0000) begin errors++; $display("FAIL abort_write got %b exp 0000", {busy, chipselect, write, done}); end
    // Abort in READ after one corrupted word: count is held, later errors never counted.
    corrupt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (599) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    corrupt = 1'b0;
    checks++; if ({busy, chipselect, done} !== 3'b000) begin errors++; $display("FAIL abort_read got %b exp 000", {busy, chipselect, done}); end
    checks++; if ({err_count, first_err_addr} !== {10'd1, 9'h005}) begin errors++; $display("FAIL abort_err_held got %h exp %h", {err_count, first_err_addr}, {10'd1, 9'h005}); end
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checks++; if ({busy, chipselect} !== 2'b00) begin errors++; $display("FAIL start_abort_idle got %b exp 00", {busy, chipselect}); end
    run_test(2'd0, 16'h0000, -1, cycles, fb);
    checks++; if ({cycles == 1026, pass, err_count} !== {2'b11, 10'd0}) begin errors++; $display("FAIL restart_after_abort cycles %0d pass %b err %0d exp 1026 1 0", cycles, pass, err_count); end
  endtask

  task automatic test_start_ignored;
    int cycles;
    logic [10:0] fb;
    run_test(2'd1, 16'h0F0F, 700, cycles, fb);
    checks++; if (cycles != 1026) begin errors++; $display("FAIL start_in_read cycles got %0d exp 1026", cycles); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL start_in_read_pass got %b exp 1", pass); end
  endtask

  task automatic test_reset_mid;
    int base;
    pattern_sel = 2'd0;
    seed = 16'h1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (700) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, pass, chipselect, write} !== 5'b00000) begin errors++; $display("FAIL mid_reset_ctrl got %b exp 00000", {busy, done, pass, chipselect, write}); end
    checks++; if ({address, writedata, err_count} !== 35'h0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", {address, writedata, err_count}); end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = cs_count;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (cs_count != base) begin errors++; $display("FAIL bus_after_reset got %0d exp %0d", cs_count, base); end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern_sel = 2'd0;
    seed = 16'h0000;
    test_reset;
    test_increment;
    test_checkerboard;
    test_lfsr;
    test_errors;
    test_abort;
    test_start_ignored;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
